// File: rtl/object_mover_pkg.sv
// Shared types and constants for the object_mover_array sprite motion engine.
package object_mover_pkg;

    localparam int FIXED_POINT_MULTIPLIER = 64;

    typedef enum logic [1:0] {
        MODE_FREE   = 2'b00,
        MODE_BOUNCE = 2'b01,
        MODE_WRAP   = 2'b10
    } mover_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SWEEP = 2'b01,
        DONE  = 2'b10
    } sweep_state_t;

    // The unused encoding 2'b11 moves like a free object.
    function automatic mover_mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'b01:   return MODE_BOUNCE;
            2'b10:   return MODE_WRAP;
            default: return MODE_FREE;
        endcase
    endfunction

endpackage

// File: rtl/object_mover_array_axis_step.sv
// Combinational single-axis motion step: hit reversal, optional gravity
// (OBJ_GRAVITY_EN), position add and free/bounce/wrap boundary resolution.
module axis_step
    import object_mover_pkg::*;
#(
    parameter int FRAC_BITS = 6,
    parameter int COORD_W   = 11,
    parameter int VEL_W     = 12,
    parameter int P_MIN     = 0,
    parameter int P_MAX     = 608
`ifdef OBJ_GRAVITY_EN
    ,
    parameter bit USE_GRAVITY = 1'b0,
    parameter int GRAVITY     = 4,
    parameter int VEL_LIMIT   = 640
`endif
) (
    input  logic [COORD_W+FRAC_BITS-1:0] pos_in,
    input  logic [VEL_W-1:0]             vel_in,
    input  logic [1:0]                   mode,
    input  logic                         hit,
    output logic [COORD_W+FRAC_BITS-1:0] pos_out,
    output logic [VEL_W-1:0]             vel_out,
    output logic                         escaped
);

    localparam int POS_W = COORD_W + FRAC_BITS;
    localparam int PIX_W = COORD_W + 1;
    localparam logic signed [PIX_W-1:0] PIX_MIN = PIX_W'(P_MIN);
    localparam logic signed [PIX_W-1:0] PIX_MAX = PIX_W'(P_MAX);
    localparam logic [POS_W-1:0] POS_MIN = {COORD_W'(P_MIN), {FRAC_BITS{1'b0}}};
    localparam logic [POS_W-1:0] POS_MAX = {COORD_W'(P_MAX), {FRAC_BITS{1'b0}}};

    // -MOST_NEG does not exist in two's complement; pin it to MOST_POS.
    function automatic logic [VEL_W-1:0] neg_sat(input logic [VEL_W-1:0] v);
        if (v == {1'b1, {(VEL_W-1){1'b0}}}) return {1'b0, {(VEL_W-1){1'b1}}};
        return -v;
    endfunction

`ifdef OBJ_GRAVITY_EN
    localparam logic signed [VEL_W+1:0] GRAV_V = (VEL_W+2)'(GRAVITY);
    localparam logic signed [VEL_W+1:0] VMAX_V = (VEL_W+2)'(VEL_LIMIT);
    localparam logic signed [VEL_W+1:0] VMIN_V = -VMAX_V;
    logic signed [VEL_W+1:0] vel_wide;
`endif

    mover_mode_t             mode_e;
    logic [VEL_W-1:0]        vel_hit;
    logic [VEL_W-1:0]        vel_eff;
    logic signed [POS_W:0]   pos_sum;
    logic signed [PIX_W-1:0] pix;
    logic                    below;
    logic                    above;

    assign mode_e = mover_mode_t'(mode);

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (defaults first), otherwise synthesis infers a latch.
        vel_hit = hit ? neg_sat(vel_in) : vel_in;
        vel_eff = vel_hit;
`ifdef OBJ_GRAVITY_EN
        vel_wide = $signed({{2{vel_hit[VEL_W-1]}}, vel_hit}) + GRAV_V;
        if (USE_GRAVITY) begin
            if (vel_wide > VMAX_V)      vel_eff = VMAX_V[VEL_W-1:0];
            else if (vel_wide < VMIN_V) vel_eff = VMIN_V[VEL_W-1:0];
            else                        vel_eff = vel_wide[VEL_W-1:0];
        end
`endif
        pos_sum = $signed({pos_in[POS_W-1], pos_in})
                + $signed({{(POS_W+1-VEL_W){vel_eff[VEL_W-1]}}, vel_eff});
        pix     = pos_sum[POS_W:FRAC_BITS];
        below   = pix < PIX_MIN;
        above   = pix > PIX_MAX;

        pos_out = pos_sum[POS_W-1:0];
        vel_out = vel_eff;
        escaped = 1'b0;
        case (mode_e)
            MODE_BOUNCE: begin
                if (below) begin
                    pos_out = POS_MIN;
                    vel_out = neg_sat(vel_eff);
                end else if (above) begin
                    pos_out = POS_MAX;
                    vel_out = neg_sat(vel_eff);
                end
            end
            MODE_WRAP: begin
                if (below)      pos_out = POS_MAX;
                else if (above) pos_out = POS_MIN;
            end
            default: escaped = below | above;
        endcase
    end

endmodule

// File: rtl/object_mover_array.sv
// Per-frame sprite motion engine: sweeps N_OBJ objects one per cycle through a
// shared X/Y axis_step pair. Optional gravity on Y via OBJ_GRAVITY_EN.
module object_mover_array
    import object_mover_pkg::*;
#(
    parameter int N_OBJ     = 4,
    parameter int FRAC_BITS = $clog2(FIXED_POINT_MULTIPLIER),
    parameter int COORD_W   = 11,
    parameter int VEL_W     = 12,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 608,
    parameter int Y_MIN     = 0,
    parameter int Y_MAX     = 448
`ifdef OBJ_GRAVITY_EN
    ,
    parameter int GRAVITY   = 4,
    parameter int VY_MAX    = 640
`endif
) (
    input  logic                                        clk,
    input  logic                                        resetN,
    input  logic                                        startOfFrame,
    input  logic                                        spawn,
    output logic                                        spawn_ready,
    input  logic [((N_OBJ > 1) ? $clog2(N_OBJ) : 1)-1:0] spawn_id,
    input  logic [COORD_W-1:0]                          spawn_x,
    input  logic [COORD_W-1:0]                          spawn_y,
    input  logic [VEL_W-1:0]                            spawn_vx,
    input  logic [VEL_W-1:0]                            spawn_vy,
    input  logic [1:0]                                  spawn_mode,
    input  logic [N_OBJ-1:0]                            kill,
    input  logic [N_OBJ-1:0]                            hit_x,
    input  logic [N_OBJ-1:0]                            hit_y,
    output logic [N_OBJ-1:0][COORD_W-1:0]               topLeftX,
    output logic [N_OBJ-1:0][COORD_W-1:0]               topLeftY,
    output logic [N_OBJ-1:0]                            active,
    output logic                                        busy,
    output logic                                        frame_done,
    output logic                                        frame_overrun
);

    localparam int POS_W = COORD_W + FRAC_BITS;
    localparam int ID_W  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(N_OBJ - 1);

    sweep_state_t    state_q, state_d;
    logic [ID_W-1:0] idx_q, idx_d;

    logic [POS_W-1:0] pos_x_q [N_OBJ];
    logic [POS_W-1:0] pos_x_d [N_OBJ];
    logic [POS_W-1:0] pos_y_q [N_OBJ];
    logic [POS_W-1:0] pos_y_d [N_OBJ];
    logic [VEL_W-1:0] vel_x_q [N_OBJ];
    logic [VEL_W-1:0] vel_x_d [N_OBJ];
    logic [VEL_W-1:0] vel_y_q [N_OBJ];
    logic [VEL_W-1:0] vel_y_d [N_OBJ];
    mover_mode_t      mode_q  [N_OBJ];
    mover_mode_t      mode_d  [N_OBJ];
    logic [N_OBJ-1:0] pend_x_q, pend_x_d;
    logic [N_OBJ-1:0] pend_y_q, pend_y_d;
    logic [N_OBJ-1:0] active_q, active_d;
    logic             overrun_q, overrun_d;

    logic [POS_W-1:0] nxt_px, nxt_py;
    logic [VEL_W-1:0] nxt_vx, nxt_vy;
    logic             esc_x, esc_y;

    // ---------------- sweep FSM ----------------
    always_ff @(posedge clk or negedge resetN) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples
        // pre-edge values regardless of statement order.
        if (!resetN) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (startOfFrame) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                end
            end
            SWEEP: begin
                if (idx_q == LAST_IDX) state_d = DONE;
                else                   idx_d   = idx_q + ID_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != IDLE);
        frame_done  = (state_q == DONE);
        spawn_ready = (state_q == IDLE);
    end

    // ---------------- shared per-slot datapath ----------------
    axis_step #(
        .FRAC_BITS (FRAC_BITS),
        .COORD_W   (COORD_W),
        .VEL_W     (VEL_W),
        .P_MIN     (X_MIN),
        .P_MAX     (X_MAX)
    ) u_step_x (
        .pos_in  (pos_x_q[idx_q]),
        .vel_in  (vel_x_q[idx_q]),
        .mode    (mode_q[idx_q]),
        .hit     (pend_x_q[idx_q]),
        .pos_out (nxt_px),
        .vel_out (nxt_vx),
        .escaped (esc_x)
    );

    axis_step #(
        .FRAC_BITS   (FRAC_BITS),
        .COORD_W     (COORD_W),
        .VEL_W       (VEL_W),
        .P_MIN       (Y_MIN),
        .P_MAX       (Y_MAX)
`ifdef OBJ_GRAVITY_EN
        ,
        .USE_GRAVITY (1'b1),
        .GRAVITY     (GRAVITY),
        .VEL_LIMIT   (VY_MAX)
`endif
    ) u_step_y (
        .pos_in  (pos_y_q[idx_q]),
        .vel_in  (vel_y_q[idx_q]),
        .mode    (mode_q[idx_q]),
        .hit     (pend_y_q[idx_q]),
        .pos_out (nxt_py),
        .vel_out (nxt_vy),
        .escaped (esc_y)
    );

    // Priority per slot: sweep update, then spawn, then new hit pulses, kill last.
    always_comb begin
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        vel_x_d   = vel_x_q;
        vel_y_d   = vel_y_q;
        mode_d    = mode_q;
        pend_x_d  = pend_x_q;
        pend_y_d  = pend_y_q;
        active_d  = active_q;
        overrun_d = overrun_q | (startOfFrame & busy);

        for (int i = 0; i < N_OBJ; i++) begin
            if (state_q == SWEEP && idx_q == ID_W'(i)) begin
                if (active_q[i]) begin
                    pos_x_d[i]  = nxt_px;
                    pos_y_d[i]  = nxt_py;
                    vel_x_d[i]  = nxt_vx;
                    vel_y_d[i]  = nxt_vy;
                    active_d[i] = !(esc_x || esc_y);
                end
                pend_x_d[i] = 1'b0;
                pend_y_d[i] = 1'b0;
            end
            if (spawn && spawn_ready && spawn_id == ID_W'(i)) begin
                pos_x_d[i]  = {spawn_x, {FRAC_BITS{1'b0}}};
                pos_y_d[i]  = {spawn_y, {FRAC_BITS{1'b0}}};
                vel_x_d[i]  = spawn_vx;
                vel_y_d[i]  = spawn_vy;
                mode_d[i]   = decode_mode(spawn_mode);
                active_d[i] = 1'b1;
                pend_x_d[i] = 1'b0;
                pend_y_d[i] = 1'b0;
            end
            // A pulse landing on the consumption edge survives to the next frame.
            pend_x_d[i] = pend_x_d[i] | hit_x[i];
            pend_y_d[i] = pend_y_d[i] | hit_y[i];
            if (kill[i]) active_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            // NOTE: the object table is architectural state the game reads right
            // after reset, so every entry is reset rather than left as RAM.
            for (int i = 0; i < N_OBJ; i++) begin
                pos_x_q[i] <= '0;
                pos_y_q[i] <= '0;
                vel_x_q[i] <= '0;
                vel_y_q[i] <= '0;
                mode_q[i]  <= MODE_FREE;
            end
            pend_x_q  <= '0;
            pend_y_q  <= '0;
            active_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            vel_x_q   <= vel_x_d;
            vel_y_q   <= vel_y_d;
            mode_q    <= mode_d;
            pend_x_q  <= pend_x_d;
            pend_y_q  <= pend_y_d;
            active_q  <= active_d;
            overrun_q <= overrun_d;
        end
    end

    // Integer pixel = arithmetic shift right, i.e. floor of the fixed-point value.
    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            topLeftX[i] = pos_x_q[i][POS_W-1:FRAC_BITS];
            topLeftY[i] = pos_y_q[i][POS_W-1:FRAC_BITS];
        end
        active        = active_q;
        frame_overrun = overrun_q;
    end

endmodule

// File: tb/tb_object_mover_array.sv
// Self-checking bench for object_mover_array: a behavioural model predicts each
// frame's outputs into a scoreboard queue that is checked when frame_done pulses.
module tb_object_mover_array;
    import object_mover_pkg::*;

    localparam int N_OBJ   = 4;
    localparam int COORD_W = 11;
    localparam int VEL_W   = 12;
    localparam int X_MIN = 0, X_MAX = 608, Y_MIN = 0, Y_MAX = 448;
    localparam int ONE = FIXED_POINT_MULTIPLIER;
`ifdef OBJ_GRAVITY_EN
    localparam int G_STEP = 4;
    localparam int VY_LIM = 640;
`else
    localparam int G_STEP = 0;
    localparam int VY_LIM = 2047;
`endif

    logic                         clk = 1'b0;
    logic                         resetN = 1'b0;
    logic                         startOfFrame = 1'b0;
    logic                         spawn = 1'b0;
    logic                         spawn_ready;
    logic [1:0]                   spawn_id = '0;
    logic [COORD_W-1:0]           spawn_x = '0, spawn_y = '0;
    logic [VEL_W-1:0]             spawn_vx = '0, spawn_vy = '0;
    logic [1:0]                   spawn_mode = '0;
    logic [N_OBJ-1:0]             kill = '0, hit_x = '0, hit_y = '0;
    logic [N_OBJ-1:0][COORD_W-1:0] topLeftX, topLeftY;
    logic [N_OBJ-1:0]             active;
    logic                         busy, frame_done, frame_overrun;

    always #5 clk = ~clk;

    object_mover_array dut (
        .clk           (clk),
        .resetN        (resetN),
        .startOfFrame  (startOfFrame),
        .spawn         (spawn),
        .spawn_ready   (spawn_ready),
        .spawn_id      (spawn_id),
        .spawn_x       (spawn_x),
        .spawn_y       (spawn_y),
        .spawn_vx      (spawn_vx),
        .spawn_vy      (spawn_vy),
        .spawn_mode    (spawn_mode),
        .kill          (kill),
        .hit_x         (hit_x),
        .hit_y         (hit_y),
        .topLeftX      (topLeftX),
        .topLeftY      (topLeftY),
        .active        (active),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_overrun (frame_overrun)
    );

    int checks = 0;
    int errors = 0;
    int frames_seen = 0;

    typedef struct {
        int              x [N_OBJ];
        int              y [N_OBJ];
        bit [N_OBJ-1:0]  act;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    // Behavioural model state (positions in 1/ONE pixel units).
    int             m_px [N_OBJ], m_py [N_OBJ], m_vx [N_OBJ], m_vy [N_OBJ], m_mode [N_OBJ];
    bit [N_OBJ-1:0] m_act, m_hx, m_hy;

    function automatic int floor_px(input int p);
        if (p >= 0) return p / ONE;
        return -((-p + ONE - 1) / ONE);
    endfunction

    function automatic int neg_sat(input int v);
        return (v == -2048) ? 2047 : -v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_OBJ; i++) begin
            m_px[i] = 0; m_py[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_mode[i] = 0;
        end
        m_act = '0; m_hx = '0; m_hy = '0;
    endtask

    task automatic model_axis(inout int pos, inout int vel, input int mode, input bit hit,
                              input bit grav, input int mn, input int mx, output bit esc);
        int pix;
        esc = 1'b0;
        if (hit) vel = neg_sat(vel);
        if (grav && G_STEP != 0) begin
            vel = vel + G_STEP;
            if (vel > VY_LIM)  vel = VY_LIM;
            if (vel < -VY_LIM) vel = -VY_LIM;
        end
        pos = pos + vel;
        pix = floor_px(pos);
        if (mode == 1) begin
            if (pix < mn)      begin pos = mn * ONE; vel = neg_sat(vel); end
            else if (pix > mx) begin pos = mx * ONE; vel = neg_sat(vel); end
        end else if (mode == 2) begin
            if (pix < mn)      pos = mx * ONE;
            else if (pix > mx) pos = mn * ONE;
        end else begin
            esc = (pix < mn) || (pix > mx);
        end
    endtask

    // Advance the model by one frame and queue the outputs expected at frame_done.
    task automatic model_frame();
        exp_t e;
        bit ex, ey;
        for (int i = 0; i < N_OBJ; i++) begin
            if (m_act[i]) begin
                model_axis(m_px[i], m_vx[i], m_mode[i], m_hx[i], 1'b0, X_MIN, X_MAX, ex);
                model_axis(m_py[i], m_vy[i], m_mode[i], m_hy[i], 1'b1, Y_MIN, Y_MAX, ey);
                if (ex || ey) m_act[i] = 1'b0;
            end
            m_hx[i] = 1'b0;
            m_hy[i] = 1'b0;
            e.x[i] = floor_px(m_px[i]);
            e.y[i] = floor_px(m_py[i]);
        end
        e.act = m_act;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: outputs are final once frame_done is high.
    always @(negedge clk) begin
        if (resetN && frame_done) begin
            frames_seen++;
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb_unexpected_frame_done at %0t: no frame was queued", $time);
            end else begin
                mon_e = sb.pop_front();
                for (int i = 0; i < N_OBJ; i++) begin
                    checks++;
                    if (int'($signed(topLeftX[i])) !== mon_e.x[i]) begin
                        errors++;
                        $display("FAIL sb_x[%0d] got %0d expected %0d", i, $signed(topLeftX[i]), mon_e.x[i]);
                    end
                    checks++;
                    if (int'($signed(topLeftY[i])) !== mon_e.y[i]) begin
                        errors++;
                        $display("FAIL sb_y[%0d] got %0d expected %0d", i, $signed(topLeftY[i]), mon_e.y[i]);
                    end
                end
                checks++;
                if (active !== mon_e.act) begin
                    errors++;
                    $display("FAIL sb_active got %b expected %b", active, mon_e.act);
                end
            end
        end
    end

    task automatic do_spawn(input int id, input int x, input int y, input int vx,
                            input int vy, input int mode);
        @(negedge clk);
        spawn = 1'b1; spawn_id = id[1:0];
        spawn_x = x[COORD_W-1:0]; spawn_y = y[COORD_W-1:0];
        spawn_vx = vx[VEL_W-1:0]; spawn_vy = vy[VEL_W-1:0];
        spawn_mode = mode[1:0];
        @(negedge clk);
        spawn = 1'b0;
        m_px[id] = x * ONE; m_py[id] = y * ONE; m_vx[id] = vx; m_vy[id] = vy;
        m_mode[id] = (mode == 3) ? 0 : mode;
        m_act[id] = 1'b1; m_hx[id] = 1'b0; m_hy[id] = 1'b0;
        checks++;
        if (int'($signed(topLeftX[id])) !== x || active[id] !== 1'b1) begin
            errors++;
            $display("FAIL spawn_load[%0d] got x=%0d act=%b expected x=%0d act=1", id,
                     $signed(topLeftX[id]), active[id], x);
        end
    endtask

    // One frame; optionally pulse hit_x[hit_slot] in that slot's own update cycle.
    task automatic run_frame(input int hit_slot);
        int k;
        @(negedge clk);
        model_frame();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL busy_rise got %b expected 1", busy);
        end
        k = 1;
        while (k < 40 && !frame_done) begin
            hit_x = '0;
            if (hit_slot >= 0 && k == hit_slot + 1) hit_x[hit_slot] = 1'b1;
            @(negedge clk);
            k++;
        end
        hit_x = '0;
        if (hit_slot >= 0) m_hx[hit_slot] = 1'b1;
        checks++;
        if (k !== N_OBJ + 1) begin
            errors++; $display("FAIL frame_done_cycle got %0d expected %0d", k, N_OBJ + 1);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL busy_fall got %b expected 0", busy);
        end
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (topLeftX !== '0 || topLeftY !== '0 || active !== '0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || frame_overrun !== 1'b0 || spawn_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_state got act=%b busy=%b done=%b ovr=%b rdy=%b expected 0 0 0 0 1",
                     active, busy, frame_done, frame_overrun, spawn_ready);
        end
        resetN = 1'b1;
    endtask

    task automatic test_free_drift();
        int start_frames;
        do_spawn(0, 280, 100, 30, 0, 0);
        start_frames = frames_seen;
        for (int f = 0; f < 64; f++) run_frame(-1);
        checks++;
        if (int'($signed(topLeftX[0])) !== 310) begin
            errors++; $display("FAIL drift_x got %0d expected 310", $signed(topLeftX[0]));
        end
        checks++;
        if (frames_seen - start_frames !== 64) begin
            errors++; $display("FAIL drift_frame_count got %0d expected 64", frames_seen - start_frames);
        end
    endtask

    task automatic test_bounce();
        do_spawn(0, 600, 100, 640, 0, 1);
        run_frame(-1);
        checks++;
        if (int'($signed(topLeftX[0])) !== 608) begin
            errors++; $display("FAIL bounce_clamp got %0d expected 608", $signed(topLeftX[0]));
        end
        run_frame(-1);
        checks++;
        if (int'($signed(topLeftX[0])) !== 598) begin
            errors++; $display("FAIL bounce_return got %0d expected 598", $signed(topLeftX[0]));
        end
    endtask

    task automatic test_wrap_and_escape();
        do_spawn(0, 5, 100, -640, 0, 2);
        run_frame(-1);
        checks++;
        if (int'($signed(topLeftX[0])) !== 608) begin
            errors++; $display("FAIL wrap_low got %0d expected 608", $signed(topLeftX[0]));
        end
        do_spawn(0, 5, 100, -640, 0, 0);
        run_frame(-1);
        checks++;
        if (active[0] !== 1'b0) begin
            errors++; $display("FAIL free_escape got active=%b expected 0", active[0]);
        end
    endtask

    task automatic test_hits();
        do_spawn(1, 100, 100, 64, 0, 1);
        do_spawn(2, 200, 100, 64, 0, 1);
        @(negedge clk);
        hit_x = 4'b0100;
        @(negedge clk);
        hit_x = '0;
        m_hx[2] = 1'b1;
        run_frame(1);
        checks++;
        if (int'($signed(topLeftX[1])) !== 101 || int'($signed(topLeftX[2])) !== 199) begin
            errors++;
            $display("FAIL hit_frame1 got x1=%0d x2=%0d expected 101 199",
                     $signed(topLeftX[1]), $signed(topLeftX[2]));
        end
        run_frame(-1);
        checks++;
        if (int'($signed(topLeftX[1])) !== 100) begin
            errors++; $display("FAIL hit_deferred got x1=%0d expected 100", $signed(topLeftX[1]));
        end
    endtask

    task automatic test_kill();
        @(negedge clk);
        kill = 4'b0010;
        @(negedge clk);
        kill = '0;
        m_act[1] = 1'b0;
        checks++;
        if (active[1] !== 1'b0) begin
            errors++; $display("FAIL kill_idle got %b expected 0", active[1]);
        end
        @(negedge clk);
        spawn = 1'b1; spawn_id = 2'd2; spawn_x = 11'd50; spawn_y = 11'd60;
        spawn_vx = '0; spawn_vy = '0; spawn_mode = 2'b00; kill = 4'b0100;
        @(negedge clk);
        spawn = 1'b0; kill = '0;
        m_px[2] = 50 * ONE; m_py[2] = 60 * ONE; m_vx[2] = 0; m_vy[2] = 0; m_mode[2] = 0;
        m_hx[2] = 1'b0; m_hy[2] = 1'b0; m_act[2] = 1'b0;
        checks++;
        if (active[2] !== 1'b0) begin
            errors++; $display("FAIL kill_beats_spawn got %b expected 0", active[2]);
        end
        run_frame(-1);
    endtask

    task automatic test_overrun();
        int k;
        int extra;
        @(negedge clk);
        model_frame();
        startOfFrame = 1'b1;
        @(negedge clk);                   // cycle 1
        startOfFrame = 1'b0;
        @(negedge clk);                   // cycle 2
        startOfFrame = 1'b1;
        @(negedge clk);                   // cycle 3
        startOfFrame = 1'b0;
        checks++;
        if (spawn_ready !== 1'b0) begin
            errors++; $display("FAIL ready_while_busy got %b expected 0", spawn_ready);
        end
        spawn = 1'b1; spawn_id = 2'd3; spawn_x = 11'd77; spawn_y = 11'd88;
        spawn_vx = 12'd64; spawn_vy = '0; spawn_mode = 2'b01;
        @(negedge clk);
        spawn = 1'b0;
        k = 0;
        while (k < 40 && !frame_done) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k >= 40) begin
            errors++; $display("FAIL overrun_frame_timeout got no frame_done expected one");
        end
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (frame_done) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++; $display("FAIL overrun_extra_sweep got %0d expected 0", extra);
        end
        checks++;
        if (frame_overrun !== 1'b1) begin
            errors++; $display("FAIL overrun_flag got %b expected 1", frame_overrun);
        end
        checks++;
        if (active[3] !== 1'b0 || topLeftX[3] !== '0) begin
            errors++;
            $display("FAIL busy_spawn_ignored got act=%b x=%0d expected 0 0", active[3], topLeftX[3]);
        end
    endtask

    task automatic test_reset_mid_sweep();
        @(negedge clk);
        model_frame();
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        @(posedge clk);
        #1 resetN = 1'b0;
        #1;
        sb.delete();
        model_reset();
        checks++;
        if (topLeftX !== '0 || topLeftY !== '0 || active !== '0 || busy !== 1'b0 ||
            frame_done !== 1'b0 || frame_overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_sweep got act=%b busy=%b done=%b ovr=%b expected all 0",
                     active, busy, frame_done, frame_overrun);
        end
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        run_frame(-1);
    endtask

`ifdef OBJ_GRAVITY_EN
    task automatic test_gravity();
        do_spawn(0, 0, 0, 0, 0, 2);
        for (int f = 0; f < 200; f++) run_frame(-1);
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_free_drift();
        test_bounce();
        test_wrap_and_escape();
        test_hits();
        test_kill();
        test_overrun();
        test_reset_mid_sweep();
`ifdef OBJ_GRAVITY_EN
        test_gravity();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL sb_leftover got %0d entries expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
